// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register feeding a combinational ROM, with a
// small FIFO of {pc, instr} entries presented to decode through a
// valid/ready handshake. Redirects flush the buffer and reload the PC.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        iClk,
  input  logic        iRst,
  output logic [31:0] oRomAddr,
  input  logic [31:0] iRomData,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPc,
  output logic        oValid,
  input  logic        iReady,
  output logic [31:0] oInstr,
  output logic [31:0] oPc,
  output logic        oMisalign
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic             misalign_q, misalign_d;

  logic [31:0] mem_pc_q    [FIFO_DEPTH];
  logic [31:0] mem_instr_q [FIFO_DEPTH];

  logic pop;
  logic push;

  assign oRomAddr  = pc_q;
  assign oValid    = (count_q != '0);
  assign oPc       = mem_pc_q[head_q];
  assign oInstr    = mem_instr_q[head_q];
  assign oMisalign = misalign_q;

  // Handshake and next-state: redirect overrides push and pop alike.
  always_comb begin
    pop        = oValid && iReady;
    push       = !iRedirect && ((count_q < DEPTH_C) || pop);
    pc_d       = pc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    misalign_d = iRedirect && (iRedirectPc[1:0] != 2'b00);
    if (iRedirect) begin
      // Flush: restart both pointers together so the buffer reads empty.
      pc_d    = {iRedirectPc[31:2], 2'b00};
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
        pc_d   = pc_q + 32'd4;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      pc_q       <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      misalign_q <= misalign_d;
    end
  end

  // Buffer storage: written at the tail on push, never reset.
  always_ff @(posedge iClk) begin
    if (push) begin
      mem_pc_q[tail_q]    <= pc_q;
      mem_instr_q[tail_q] <= iRomData;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a ROM model plus a queue of expected fetch PCs that
// is pushed when the bench drives a fetch-accepting cycle and popped on pop.
module tb_inst_fetch;

  localparam int DEPTH = 2;

  logic        iClk;
  logic        iRst;
  logic [31:0] oRomAddr;
  logic [31:0] iRomData;
  logic        iRedirect;
  logic [31:0] iRedirectPc;
  logic        oValid;
  logic        iReady;
  logic [31:0] oInstr;
  logic [31:0] oPc;
  logic        oMisalign;

  int ntests = 0;
  int nfail  = 0;

  logic [31:0] sb[$];
  logic [31:0] mpc;
  logic        mmis;

  inst_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .iClk(iClk), .iRst(iRst), .oRomAddr(oRomAddr), .iRomData(iRomData),
    .iRedirect(iRedirect), .iRedirectPc(iRedirectPc), .oValid(oValid),
    .iReady(iReady), .oInstr(oInstr), .oPc(oPc), .oMisalign(oMisalign)
  );

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    if (a == 32'd0) return 32'h002083B3;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign iRomData = rom_f(oRomAddr);

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Drive one cycle, advance the reference model across the edge, sample at +1.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
    logic pop_m, push_m;
    iReady      = rdy;
    iRedirect   = redir;
    iRedirectPc = rpc;
    pop_m  = (sb.size() != 0) && rdy;
    push_m = !redir && ((sb.size() < DEPTH) || pop_m);
    @(posedge iClk);
    if (redir) begin
      sb.delete();
      mpc  = {rpc[31:2], 2'b00};
      mmis = (rpc[1:0] != 2'b00);
    end else begin
      mmis = 1'b0;
      if (pop_m) void'(sb.pop_front());
      if (push_m) begin
        sb.push_back(mpc);
        mpc = mpc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    iRst = 1'b1; iReady = 1'b0; iRedirect = 1'b0; iRedirectPc = '0;
    @(posedge iClk); #1;
    sb.delete(); mpc = 32'd0; mmis = 1'b0;
    iRst = 1'b0;
  endtask

  task automatic test_reset();
    iRst = 1'b1; iReady = 1'b1; iRedirect = 1'b0; iRedirectPc = '0;
    #2;
    ntests++;
    if (oValid !== 1'b0 || oMisalign !== 1'b0 || oRomAddr !== 32'd0) begin
      nfail++;
      $display("FAIL reset_state: valid=%b mis=%b addr=%h want 0 0 0", oValid, oMisalign, oRomAddr);
    end
    @(posedge iClk); #1;
    sb.delete(); mpc = 32'd0; mmis = 1'b0;
    iRst = 1'b0;
    cycle(1'b1, 1'b0, 32'd0);
    ntests++;
    if (oValid !== 1'b1 || oPc !== 32'd0 || oInstr !== 32'h002083B3) begin
      nfail++;
      $display("FAIL first_fetch: valid=%b pc=%h instr=%h want 1 0 002083b3", oValid, oPc, oInstr);
    end
    cycle(1'b1, 1'b0, 32'd0);
    ntests++;
    if (oValid !== 1'b1 || oPc !== 32'd4 || oInstr !== rom_f(32'd4)) begin
      nfail++;
      $display("FAIL second_fetch: valid=%b pc=%h instr=%h want 1 4 %h", oValid, oPc, oInstr, rom_f(32'd4));
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'd0);
    ntests++;
    if (oValid !== 1'b1 || oPc !== 32'd0 || oRomAddr !== 32'd8 || sb.size() != 2) begin
      nfail++;
      $display("FAIL stall_full: valid=%b pc=%h addr=%h want 1 0 8", oValid, oPc, oRomAddr);
    end
    for (int i = 0; i < 4; i++) begin
      iReady = 1'b1;
      ntests++;
      if (oValid !== 1'b1 || oPc !== 32'(4 * i) || oInstr !== rom_f(32'(4 * i))) begin
        nfail++;
        $display("FAIL drain_seq%0d: valid=%b pc=%h instr=%h want 1 %h %h", i, oValid, oPc, oInstr,
                 32'(4 * i), rom_f(32'(4 * i)));
      end
      cycle(1'b1, 1'b0, 32'd0);
    end
  endtask

  task automatic test_redirect();
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 32'd172);
    ntests++;
    if (oValid !== 1'b0 || oRomAddr !== 32'd172 || oMisalign !== 1'b0) begin
      nfail++;
      $display("FAIL redirect_flush: valid=%b addr=%h mis=%b want 0 172 0", oValid, oRomAddr, oMisalign);
    end
    cycle(1'b0, 1'b0, 32'd0);
    ntests++;
    if (oValid !== 1'b1 || oPc !== 32'd172 || oInstr !== rom_f(32'd172)) begin
      nfail++;
      $display("FAIL redirect_target: valid=%b pc=%h instr=%h want 1 172", oValid, oPc, oInstr);
    end
  endtask

  task automatic test_misalign();
    cycle(1'b1, 1'b1, 32'h0000_00D2);
    ntests++;
    if (oMisalign !== 1'b1 || oRomAddr !== 32'd208 || oValid !== 1'b0) begin
      nfail++;
      $display("FAIL misalign_pulse: mis=%b addr=%h valid=%b want 1 208 0", oMisalign, oRomAddr, oValid);
    end
    cycle(1'b1, 1'b0, 32'd0);
    ntests++;
    if (oMisalign !== 1'b0 || oPc !== 32'd208) begin
      nfail++;
      $display("FAIL misalign_clear: mis=%b pc=%h want 0 208", oMisalign, oPc);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 1'b1, 32'h100);
    cycle(1'b1, 1'b1, 32'h200);
    ntests++;
    if (oValid !== 1'b0 || oRomAddr !== 32'h200) begin
      nfail++;
      $display("FAIL b2b_redirect: valid=%b addr=%h want 0 200", oValid, oRomAddr);
    end
    cycle(1'b1, 1'b0, 32'd0);
    ntests++;
    if (oValid !== 1'b1 || oPc !== 32'h200) begin
      nfail++;
      $display("FAIL b2b_target: valid=%b pc=%h want 1 200", oValid, oPc);
    end
  endtask

  task automatic test_redirect_pop();
    logic [31:0] old_pc;
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    old_pc = oPc;
    cycle(1'b1, 1'b1, 32'h300);
    ntests++;
    if (oValid !== 1'b0) begin
      nfail++;
      $display("FAIL redir_pop_empty: valid=%b want 0", oValid);
    end
    cycle(1'b1, 1'b0, 32'd0);
    ntests++;
    if (oValid !== 1'b1 || oPc !== 32'h300 || oPc === old_pc + 32'd4) begin
      nfail++;
      $display("FAIL redir_pop_head: valid=%b pc=%h want 1 300", oValid, oPc);
    end
  endtask

  task automatic test_random();
    logic rdy, rd;
    logic [31:0] tgt;
    for (int i = 0; i < 60; i++) begin
      rdy = 1'($urandom_range(0, 1));
      rd  = ($urandom_range(0, 9) == 0);
      tgt = $urandom & 32'h0000_0FFF;
      cycle(rdy, rd, tgt);
      ntests++;
      if (oValid !== (sb.size() != 0) || oRomAddr !== mpc || oMisalign !== mmis ||
          (sb.size() != 0 && (oPc !== sb[0] || oInstr !== rom_f(sb[0])))) begin
        nfail++;
        $display("FAIL random%0d: valid=%b addr=%h mis=%b pc=%h instr=%h want valid=%b addr=%h mis=%b pc=%h",
                 i, oValid, oRomAddr, oMisalign, oPc, oInstr, (sb.size() != 0), mpc, mmis,
                 (sb.size() != 0) ? sb[0] : 32'd0);
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    #2;
    iRst = 1'b1;
    #1;
    ntests++;
    if (oValid !== 1'b0 || oRomAddr !== 32'd0 || oMisalign !== 1'b0) begin
      nfail++;
      $display("FAIL async_reset: valid=%b addr=%h mis=%b want 0 0 0", oValid, oRomAddr, oMisalign);
    end
    @(posedge iClk); #1;
    sb.delete(); mpc = 32'd0; mmis = 1'b0;
    iRst = 1'b0;
    cycle(1'b1, 1'b0, 32'd0);
    ntests++;
    if (oValid !== 1'b1 || oPc !== 32'd0 || oInstr !== 32'h002083B3) begin
      nfail++;
      $display("FAIL after_reset: valid=%b pc=%h instr=%h want 1 0 002083b3", oValid, oPc, oInstr);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_misalign();
    test_back_to_back();
    test_redirect_pop();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded at reset; it SHALL be word-aligned.
REQ-002 Parameter FIFO_DEPTH, default 2, is the number of fetch-buffer entries; it SHALL be a power of two and at least 2.
REQ-003 Port iClk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port iRst  input  1  is the reset; it SHALL be asynchronous and active-high.
REQ-005 Port oRomAddr  output  32  is the byte address driven to the instruction ROM; it SHALL equal the current PC.
REQ-006 Port iRomData  input  32  is the instruction word returned combinationally by the ROM for oRomAddr in the same cycle.
REQ-007 Port iRedirect  input  1  requests a PC redirect (taken branch, JAL or JALR) this cycle.
REQ-008 Port iRedirectPc  input  32  is the redirect target byte address.
REQ-009 Port oValid  output  1  indicates that the buffer head holds a valid instruction for decode.
REQ-010 Port iReady  input  1  indicates that decode accepts the head entry this cycle.
REQ-011 Port oInstr  output  32  is the head-entry instruction word.
REQ-012 Port oPc  output  32  is the head-entry fetch PC.
REQ-013 Port oMisalign  output  1  is a one-cycle pulse flagging a redirect target with nonzero bits [1:0].

Function
REQ-014 The block SHALL hold a PC register and a FIFO of FIFO_DEPTH entries, each entry being {pc[31:0], instr[31:0]}.
REQ-015 pop SHALL be defined as oValid && iReady.
REQ-016 push SHALL be defined as !iRedirect && (count < FIFO_DEPTH || pop).
REQ-017 On push, the block SHALL write {PC, iRomData} at the tail and SHALL set PC <= PC + 4, using modulo-2^32 wrap with no overflow flag.
REQ-018 When the FIFO is full and there is no pop, the block SHALL leave PC unchanged, SHALL leave FIFO contents unchanged, and SHALL hold oRomAddr stable.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged; this applies at full and at one entry.
REQ-020 oValid SHALL equal (count != 0); oInstr and oPc SHALL be driven from the head entry and SHALL be don't-care when oValid=0.
REQ-021 Throughput: with iReady held at 1 and no redirect, the block SHALL present one new instruction per cycle.
REQ-022 Latency: an instruction fetched at edge N SHALL appear on oValid/oInstr after edge N, with a 1-cycle fetch-to-decode latency.
REQ-023 On iRedirect=1, at the next edge the block SHALL set count <= 0 and PC <= {iRedirectPc[31:2], 2'b00}, SHALL NOT push, and SHALL discard any pop in that cycle; redirect SHALL have priority over all other events.
REQ-024 oMisalign SHALL be registered and SHALL be 1 for exactly the cycle after a redirect whose iRedirectPc[1:0] != 0.
REQ-025 Back-to-back redirects SHALL each take effect, with the last redirect winning; no entry SHALL be pushed during any redirect cycle.
REQ-026 In the cycle after a redirect, oValid SHALL be 0, and the target instruction SHALL be visible one cycle later.
REQ-027 oValid, oInstr and oPc SHALL remain stable while oValid=1 and iReady=0.
REQ-028 The head and tail pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-029 While iRst=1, the block SHALL hold PC=RESET_PC, count=0, head=tail=0, oValid=0 and oMisalign=0, independent of iClk.
REQ-030 Reset asserted mid-operation SHALL immediately clear the FIFO and oValid; the first push after release SHALL use PC=RESET_PC.
REQ-031 FIFO data storage need not be reset.

Verification
REQ-032 Bench SHALL check: reset release with iReady=1 and ROM word0=32'h002083B3 -> after edge 1 oValid=1, oPc=0, oInstr=32'h002083B3; next cycle oPc=4.
REQ-033 Bench SHALL check: iReady=0 for 5 cycles from reset -> count saturates at 2, oPc=0 held, oRomAddr=8 held; iReady=1 -> oPc sequence 0,4,8,12 with no gaps.
REQ-034 Bench SHALL check: iRedirect=1 with iRedirectPc=172 while 2 entries are held -> next cycle oValid=0, oRomAddr=172; the cycle after, oPc=172.
REQ-035 Bench SHALL check: iRedirectPc=32'h0000_00D2 -> oRomAddr=208 and oMisalign=1 for exactly one cycle.
REQ-036 Bench SHALL check: iRedirect=1 and pop in the same cycle -> the popped entry is not re-presented and the buffer is emptied.
REQ-037 Bench SHALL check: iRst asserted asynchronously between edges with 2 entries held -> oValid falls before the next edge; after release oPc=RESET_PC.
